// File: rtl/panel_scan_ctrl.sv
// HUB75 scan/timing generator: framebuffer read addresses, shared PWM reference and panel control pins.
// One line = SHIFT (2 cycles/column), TAIL, BLANK, LATCH, ADVANCE; linear PWM, one step per full row sweep.
module panel_scan_ctrl #(
    parameter int PWM_WIDTH = 12,
    parameter int COL_BITS  = 5,
    parameter int ROW_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [COL_BITS-1:0]  col_addr,
    output logic [ROW_BITS-1:0]  row_addr,
    output logic [PWM_WIDTH-1:0] pwm,
    output logic                 panel_clk,
    output logic                 panel_lat,
    output logic                 panel_oe_n,
    output logic [ROW_BITS-1:0]  panel_row,
    output logic                 frame_start
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_TAIL    = 3'd2,
        S_BLANK   = 3'd3,
        S_LATCH   = 3'd4,
        S_ADVANCE = 3'd5
    } state_t;

    localparam logic [COL_BITS:0] CNT_LAST = {(COL_BITS+1){1'b1}};

    state_t               r_state, w_state_nxt;
    logic [COL_BITS:0]    r_cnt, w_cnt_nxt;
    logic [ROW_BITS-1:0]  r_row, w_row_nxt;
    logic [PWM_WIDTH-1:0] r_pwm, w_pwm_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [ROW_BITS-1:0]  r_prow, w_prow_nxt;
    logic                 r_clk, r_lat, r_oe_n, r_fs;
    logic                 w_clk_nxt, w_lat_nxt, w_oe_n_nxt, w_fs_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_pwm_nxt   = r_pwm;
        w_valid_nxt = r_valid;
        w_prow_nxt  = r_prow;
        w_fs_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            S_SHIFT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) w_state_nxt = S_TAIL;
            end
            S_TAIL:  w_state_nxt = S_BLANK;
            S_BLANK: begin
                // Entering LATCH: the new row select appears together with the latch strobe.
                w_state_nxt = S_LATCH;
                w_prow_nxt  = r_row;
                w_valid_nxt = 1'b1;
            end
            S_LATCH: begin
                w_state_nxt = S_ADVANCE;
                w_cnt_nxt   = '0;
            end
            S_ADVANCE: begin
                w_cnt_nxt = '0;
                w_row_nxt = r_row + 1'b1;
                if (r_row == '1) begin
                    w_pwm_nxt = r_pwm + 1'b1;
                    w_fs_nxt  = (r_pwm == '1);
                end
                w_state_nxt = en ? S_SHIFT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Output values are decoded from the next state so every pin comes straight off a flop.
        w_clk_nxt  = ((w_state_nxt == S_SHIFT) && !w_cnt_nxt[0] && (w_cnt_nxt[COL_BITS:1] != '0))
                     || (w_state_nxt == S_TAIL);
        w_lat_nxt  = (w_state_nxt == S_LATCH);
        w_oe_n_nxt = !(((w_state_nxt == S_SHIFT) || (w_state_nxt == S_TAIL)) && w_valid_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_pwm   <= '0;
            r_valid <= 1'b0;
            r_prow  <= '0;
            r_clk   <= 1'b0;
            r_lat   <= 1'b0;
            r_oe_n  <= 1'b1;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_pwm   <= w_pwm_nxt;
            r_valid <= w_valid_nxt;
            r_prow  <= w_prow_nxt;
            r_clk   <= w_clk_nxt;
            r_lat   <= w_lat_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_fs    <= w_fs_nxt;
        end
    end

    assign col_addr    = r_cnt[COL_BITS:1];
    assign row_addr    = r_row;
    assign pwm         = r_pwm;
    assign panel_clk   = r_clk;
    assign panel_lat   = r_lat;
    assign panel_oe_n  = r_oe_n;
    assign panel_row   = r_prow;
    assign frame_start = r_fs;

endmodule
